// File: rtl/pc_sequencer.sv
// Fetch-side next-PC generator with a circular return-address stack.
// Arbitrates execute branches, decode jump/call/ret, loop redirects and stalls.
module pc_sequencer #(
    parameter int              WIDTH     = 16,
    parameter int              RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int              JMP_BITS  = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [WIDTH-1:0]             branch_target,
    input  logic                         jump,
    input  logic                         call,
    input  logic                         ret,
    input  logic [JMP_BITS-1:0]          jump_field,
    input  logic                         loop_taken,
    input  logic [WIDTH-1:0]             loop_target,
    output logic [WIDTH-1:0]             pc_out,
    output logic                         redirect,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_inc, jmp_tgt, ras_top;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             redir_q, redir_d;
    logic             push;
    logic             ras_full, ras_empty;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    assign pc_inc    = pc_q + 1'b1;
    assign jmp_tgt   = {pc_q[WIDTH-1:JMP_BITS], jump_field};
    assign ras_full  = (count_q == CW'(RAS_DEPTH));
    assign ras_empty = (count_q == '0);
    // ptr points at the next free slot; it wraps onto the oldest entry when full
    assign ras_top   = ras_q[ptr_q - 1'b1];

    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        redir_d = 1'b0;
        push    = 1'b0;
        if (branch_taken) begin
            pc_d    = branch_target;
            redir_d = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (!ras_empty) begin
                pc_d    = ras_top;
                ptr_d   = ptr_q - 1'b1;
                count_d = count_q - 1'b1;
                redir_d = 1'b1;
            end else begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
            end
        end else if (call) begin
            push    = 1'b1;
            ptr_d   = ptr_q + 1'b1;
            pc_d    = jmp_tgt;
            redir_d = 1'b1;
            if (ras_full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (jump) begin
            pc_d    = jmp_tgt;
            redir_d = 1'b1;
        end else if (loop_taken) begin
            pc_d    = loop_target;
            redir_d = 1'b1;
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            redir_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            redir_q <= redir_d;
        end
    end

    // Entry contents need no reset; only the pointer and count are reset
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ras_q[ptr_q] <= pc_inc;
        end
    end

    assign pc_out        = pc_q;
    assign redirect      = redir_q;
    assign ras_count     = count_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule
